// File: rtl/bus_pkg.sv
// Shared encodings for the 68030-style bus cycle sequencer: SIZ, DSACK port widths,
// sequencer states and byte-lane indices (lane 0 = D31:24).
package bus_pkg;

    typedef enum logic [1:0] {
        SIZ_LONG  = 2'b00,
        SIZ_BYTE  = 2'b01,
        SIZ_WORD  = 2'b10,
        SIZ_3BYTE = 2'b11
    } siz_e;

    typedef enum logic [1:0] {
        DSACK_32   = 2'b00,
        DSACK_16   = 2'b01,
        DSACK_8    = 2'b10,
        DSACK_NONE = 2'b11
    } dsack_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_STROBE,
        S_NEGATE,
        S_DONE
    } state_e;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    // SIZ encodes the byte count modulo 4, so 00 means four bytes.
    function automatic logic [2:0] siz_bytes(input logic [1:0] siz);
        return (siz == SIZ_LONG) ? 3'd4 : {1'b0, siz};
    endfunction

    function automatic logic [2:0] port_bytes(input logic [1:0] dsack);
        case (dsack)
            DSACK_32: return 3'd4;
            DSACK_16: return 3'd2;
            DSACK_8:  return 3'd1;
            default:  return 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/bus_cycle_sequencer_if.sv
// Request-side and 68030 bus-side signals of the bus cycle sequencer.
// master = the sequencer itself, slave = requesting agent plus bus target.
interface bus_cycle_sequencer_if;

    logic        req;
    logic        req_rn_w;
    logic [31:0] req_addr;
    logic [1:0]  req_siz;
    logic [31:0] req_wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;

    logic [31:0] addr;
    logic [1:0]  siz;
    logic        rn_w;
    logic        as_n;
    logic        ds_n;
    logic [31:0] data_out;
    logic        data_oe;
    logic [31:0] data_in;
    logic [1:0]  dsack_n;
    logic        berr_n;

    modport master (
        input  req, req_rn_w, req_addr, req_siz, req_wdata,
        output busy, done, err, rdata,
        output addr, siz, rn_w, as_n, ds_n, data_out, data_oe,
        input  data_in, dsack_n, berr_n
    );

    modport slave (
        output req, req_rn_w, req_addr, req_siz, req_wdata,
        input  busy, done, err, rdata,
        input  addr, siz, rn_w, as_n, ds_n, data_out, data_oe,
        output data_in, dsack_n, berr_n
    );

endinterface

// File: rtl/bus_cycle_sequencer_lane_steer.sv
// Combinational byte-lane logic: write-data lane steering, read byte extraction and
// the number of bytes a port of the acknowledged width accepts this cycle.
module lane_steer
    import bus_pkg::*;
(
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_remaining,
    input  logic [1:0]  i_dsack,
    input  logic [31:0] i_wbytes,
    input  logic [31:0] i_data_in,
    output logic [31:0] o_data_out,
    output logic [2:0]  o_accepted,
    output logic [31:0] o_rbytes
);

    logic [7:0]  w_lane0;
    logic [7:0]  w_lane1;
    logic [7:0]  w_lane2;
    logic [7:0]  w_lane3;
    logic [1:0]  w_rel2;
    logic [1:0]  w_rel3;
    logic [2:0]  w_width;
    logic [1:0]  w_start;
    logic [2:0]  w_room;
    logic [31:0] w_shifted;

    // k-th remaining operand byte, most significant first.
    function automatic logic [7:0] wbyte(input logic [31:0] bytes, input logic [1:0] k);
        return bytes[8*(3-k) +: 8];
    endfunction

    always_comb begin
        w_rel2  = LANE2 - i_off;
        w_rel3  = LANE3 - i_off;
        w_lane0 = wbyte(i_wbytes, LANE0);
        w_lane1 = i_off[0] ? wbyte(i_wbytes, LANE0) : wbyte(i_wbytes, LANE1);
        w_lane2 = w_lane0;
        w_lane3 = w_lane1;
        if (i_off <= LANE2 && {1'b0, w_rel2} < i_remaining) begin
            w_lane2 = wbyte(i_wbytes, w_rel2);
        end
        if ({1'b0, w_rel3} < i_remaining) begin
            w_lane3 = wbyte(i_wbytes, w_rel3);
        end
        o_data_out = {w_lane0, w_lane1, w_lane2, w_lane3};
    end

    // The first active lane of a narrow port equals the address misalignment within it.
    always_comb begin
        w_width = port_bytes(i_dsack);
        case (i_dsack)
            DSACK_32: w_start = i_off;
            DSACK_16: w_start = {1'b0, i_off[0]};
            default:  w_start = LANE0;
        endcase
        w_room     = w_width - {1'b0, w_start};
        o_accepted = (i_remaining < w_room) ? i_remaining : w_room;
        w_shifted  = i_data_in << {w_start, 3'b000};
        o_rbytes   = (o_accepted == 3'd0) ? '0
                                          : (w_shifted >> {3'd4 - o_accepted, 3'b000});
    end

endmodule

// File: rtl/bus_cycle_sequencer.sv
// 68030-style bus initiator with dynamic bus sizing from DSACK1:0.
// Optional S_STROBE timeout enabled by defining BUS_SEQ_TIMEOUT_EN.
module bus_cycle_sequencer
    import bus_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
)
(
    input  logic                  clock,
    input  logic                  reset_n,
    bus_cycle_sequencer_if.master bus
);

    state_e      r_state;
    state_e      w_next;
    logic [1:0]  r_dsack_meta;
    logic [1:0]  r_dsack_sync;
    logic        r_berr_meta;
    logic        r_berr_sync;
    logic [31:0] r_addr;
    logic [2:0]  r_remaining;
    logic        r_rn_w;
    logic [31:0] r_wbytes;
    logic [31:0] r_acc;
    logic [31:0] r_rdata;
    logic        r_err;

    logic        w_ack;
    logic        w_timeout;
    logic        w_fault;
    logic [31:0] w_data_out;
    logic [2:0]  w_accepted;
    logic [31:0] w_rbytes;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_dsack_meta <= '1;
            r_dsack_sync <= '1;
            r_berr_meta  <= 1'b1;
            r_berr_sync  <= 1'b1;
        end else begin
            r_dsack_meta <= bus.dsack_n;
            r_dsack_sync <= r_dsack_meta;
            r_berr_meta  <= bus.berr_n;
            r_berr_sync  <= r_berr_meta;
        end
    end

`ifdef BUS_SEQ_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_tmo <= '0;
        end else if (r_state == S_ADDR) begin
            r_tmo <= '0;
        end else if (r_state == S_STROBE && !w_timeout) begin
            r_tmo <= r_tmo + TW'(1);
        end
    end

    assign w_timeout = (r_state == S_STROBE) && (r_tmo == TW'(TIMEOUT_CYCLES - 1));
`else
    logic w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign w_timeout            = 1'b0;
`endif

    assign w_ack   = (r_dsack_sync != DSACK_NONE);
    assign w_fault = !r_berr_sync || w_timeout;

    lane_steer u_lane_steer (
        .i_off       (r_addr[1:0]),
        .i_remaining (r_remaining),
        .i_dsack     (r_dsack_sync),
        .i_wbytes    (r_wbytes),
        .i_data_in   (bus.data_in),
        .o_data_out  (w_data_out),
        .o_accepted  (w_accepted),
        .o_rbytes    (w_rbytes)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (bus.req) w_next = S_ADDR;
            S_ADDR:   w_next = S_STROBE;
            S_STROBE: if (w_fault || w_ack) w_next = S_NEGATE;
            S_NEGATE: begin
                if (!w_ack) begin
                    w_next = (r_err || r_remaining == 3'd0) ? S_DONE : S_ADDR;
                end
            end
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Bytes are tallied on the acknowledging edge, while data_in is still valid;
    // a fault (BERR or timeout) takes priority and moves no bytes.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_rn_w      <= 1'b1;
            r_wbytes    <= '0;
            r_acc       <= '0;
            r_rdata     <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.req) begin
                        r_addr      <= bus.req_addr;
                        r_remaining <= siz_bytes(bus.req_siz);
                        r_rn_w      <= bus.req_rn_w;
                        r_wbytes    <= bus.req_wdata << {3'd4 - siz_bytes(bus.req_siz), 3'b000};
                        r_acc       <= '0;
                        r_err       <= 1'b0;
                    end
                end
                S_STROBE: begin
                    if (w_fault) begin
                        r_err <= 1'b1;
                    end else if (w_ack) begin
                        r_addr      <= r_addr + 32'(w_accepted);
                        r_remaining <= r_remaining - w_accepted;
                        r_wbytes    <= r_wbytes << {w_accepted, 3'b000};
                        r_acc       <= (r_acc << {w_accepted, 3'b000}) | w_rbytes;
                    end
                end
                S_NEGATE: begin
                    if (w_next == S_DONE) begin
                        r_rdata <= (r_rn_w && !r_err) ? r_acc : '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.as_n    = 1'b1;
        bus.ds_n    = 1'b1;
        bus.data_oe = 1'b0;
        bus.busy    = (r_state != S_IDLE);
        bus.done    = (r_state == S_DONE);
        if (r_state == S_STROBE) begin
            bus.as_n    = 1'b0;
            bus.ds_n    = 1'b0;
            bus.data_oe = !r_rn_w;
        end
    end

    assign bus.addr     = r_addr;
    assign bus.siz      = r_remaining[1:0];
    assign bus.rn_w     = r_rn_w;
    assign bus.data_out = w_data_out;
    assign bus.err      = r_err;
    assign bus.rdata    = r_rdata;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Directed self-checking bench for bus_cycle_sequencer; the timeout step runs only
// when BUS_SEQ_TIMEOUT_EN is defined.
module tb_bus_cycle_sequencer;

    logic clock = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    bus_cycle_sequencer_if u_bus ();

    bus_cycle_sequencer #(.TIMEOUT_CYCLES(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (u_bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic rnw, input logic [31:0] a, input logic [1:0] s,
                            input logic [31:0] wd);
        @(negedge clock);
        u_bus.req       = 1'b1;
        u_bus.req_rn_w  = rnw;
        u_bus.req_addr  = a;
        u_bus.req_siz   = s;
        u_bus.req_wdata = wd;
        @(negedge clock);
        u_bus.req       = 1'b0;
    endtask

    task automatic bus_cycle(input string tag, input logic [31:0] exp_addr,
                             input logic [1:0] exp_siz, input logic exp_oe,
                             input logic [31:0] dmask, input logic [31:0] exp_dout,
                             input logic [1:0] ack, input logic berr, input logic [31:0] din);
        for (int n = 0; n < 40 && u_bus.as_n !== 1'b0; n++) @(negedge clock);
        chk({tag, ".as_n"}, 32'(u_bus.as_n), 32'd0);
        chk({tag, ".ds_n"}, 32'(u_bus.ds_n), 32'd0);
        chk({tag, ".addr"}, u_bus.addr, exp_addr);
        chk({tag, ".siz"}, 32'(u_bus.siz), 32'(exp_siz));
        chk({tag, ".data_oe"}, 32'(u_bus.data_oe), 32'(exp_oe));
        if (dmask != 32'd0) chk({tag, ".data_out"}, u_bus.data_out & dmask, exp_dout & dmask);
        u_bus.dsack_n = ack;
        u_bus.berr_n  = berr;
        u_bus.data_in = din;
        for (int n = 0; n < 40 && u_bus.as_n !== 1'b1; n++) @(negedge clock);
        chk({tag, ".negate"}, 32'(u_bus.as_n), 32'd1);
        u_bus.dsack_n = 2'b11;
        u_bus.berr_n  = 1'b1;
        u_bus.data_in = 32'h0;
    endtask

    task automatic wait_done(input string tag, input logic exp_err, input logic [31:0] exp_rdata,
                             input int exp_strobes);
        int strobes = 0;
        for (int n = 0; n < 80 && u_bus.done !== 1'b1; n++) begin
            @(negedge clock);
            if (u_bus.as_n === 1'b0) strobes++;
        end
        chk({tag, ".done"}, 32'(u_bus.done), 32'd1);
        chk({tag, ".err"}, 32'(u_bus.err), 32'(exp_err));
        chk({tag, ".rdata"}, u_bus.rdata, exp_rdata);
        chk({tag, ".strobes"}, 32'(strobes), 32'(exp_strobes));
        @(negedge clock);
        chk({tag, ".idle_busy"}, 32'(u_bus.busy), 32'd0);
        chk({tag, ".idle_done"}, 32'(u_bus.done), 32'd0);
    endtask

    initial begin
        int activity;
        reset_n         = 1'b0;
        u_bus.req       = 1'b0;
        u_bus.req_rn_w  = 1'b1;
        u_bus.req_addr  = 32'h0;
        u_bus.req_siz   = 2'b00;
        u_bus.req_wdata = 32'h0;
        u_bus.data_in   = 32'h0;
        u_bus.dsack_n   = 2'b11;
        u_bus.berr_n    = 1'b1;
        repeat (3) @(negedge clock);
        chk("rst.as_n", 32'(u_bus.as_n), 32'd1);
        chk("rst.ds_n", 32'(u_bus.ds_n), 32'd1);
        chk("rst.data_oe", 32'(u_bus.data_oe), 32'd0);
        chk("rst.busy", 32'(u_bus.busy), 32'd0);
        chk("rst.done", 32'(u_bus.done), 32'd0);
        chk("rst.err", 32'(u_bus.err), 32'd0);
        chk("rst.rn_w", 32'(u_bus.rn_w), 32'd1);
        chk("rst.addr", u_bus.addr, 32'd0);
        chk("rst.siz", 32'(u_bus.siz), 32'd0);
        chk("rst.rdata", u_bus.rdata, 32'd0);
        reset_n = 1'b1;

        // long write, 32-bit port, plus a req pulse while busy that must be ignored
        start_op(1'b0, 32'h0000_1000, 2'b00, 32'h1122_3344);
        chk("t1.busy", 32'(u_bus.busy), 32'd1);
        u_bus.req      = 1'b1;
        u_bus.req_addr = 32'hDEAD_0000;
        @(negedge clock);
        u_bus.req      = 1'b0;
        bus_cycle("t1", 32'h0000_1000, 2'b00, 1'b1, 32'hFFFF_FFFF, 32'h1122_3344, 2'b00, 1'b1, 32'h0);
        wait_done("t1", 1'b0, 32'h0, 0);
        activity = 0;
        repeat (4) begin
            @(negedge clock);
            if (u_bus.as_n === 1'b0 || u_bus.busy === 1'b1) activity++;
        end
        chk("t1.ignored_req", 32'(activity), 32'd0);

        // long write, 8-bit port, odd address
        start_op(1'b0, 32'h0000_1001, 2'b00, 32'h1122_3344);
        bus_cycle("t2c1", 32'h0000_1001, 2'b00, 1'b1, 32'hFF00_0000, 32'h1100_0000, 2'b10, 1'b1, 32'h0);
        bus_cycle("t2c2", 32'h0000_1002, 2'b11, 1'b1, 32'hFF00_0000, 32'h2200_0000, 2'b10, 1'b1, 32'h0);
        bus_cycle("t2c3", 32'h0000_1003, 2'b10, 1'b1, 32'hFF00_0000, 32'h3300_0000, 2'b10, 1'b1, 32'h0);
        bus_cycle("t2c4", 32'h0000_1004, 2'b01, 1'b1, 32'hFF00_0000, 32'h4400_0000, 2'b10, 1'b1, 32'h0);
        wait_done("t2", 1'b0, 32'h0, 0);

        // long write, 32-bit port, offset 2
        start_op(1'b0, 32'h0000_3002, 2'b00, 32'h1122_3344);
        bus_cycle("t3c1", 32'h0000_3002, 2'b00, 1'b1, 32'hFFFF_FFFF, 32'h1122_1122, 2'b00, 1'b1, 32'h0);
        bus_cycle("t3c2", 32'h0000_3004, 2'b10, 1'b1, 32'hFFFF_FFFF, 32'h3344_3344, 2'b00, 1'b1, 32'h0);
        wait_done("t3", 1'b0, 32'h0, 0);

        // word read, 16-bit port, odd address
        start_op(1'b1, 32'h0000_2003, 2'b10, 32'h0);
        bus_cycle("t4c1", 32'h0000_2003, 2'b10, 1'b0, 32'h0, 32'h0, 2'b01, 1'b1, 32'h55AB_6677);
        bus_cycle("t4c2", 32'h0000_2004, 2'b01, 1'b0, 32'h0, 32'h0, 2'b01, 1'b1, 32'hCD99_8877);
        wait_done("t4", 1'b0, 32'h0000_ABCD, 0);

        // long read, 16-bit port, bus error on the second cycle
        start_op(1'b1, 32'h0000_4000, 2'b00, 32'h0);
        bus_cycle("t5c1", 32'h0000_4000, 2'b00, 1'b0, 32'h0, 32'h0, 2'b01, 1'b1, 32'hDEAD_1234);
        bus_cycle("t5c2", 32'h0000_4002, 2'b10, 1'b0, 32'h0, 32'h0, 2'b11, 1'b0, 32'h0);
        wait_done("t5", 1'b1, 32'h0, 0);

        // 3-byte read, 32-bit port, offset 1
        start_op(1'b1, 32'h0000_5001, 2'b11, 32'h0);
        bus_cycle("t7", 32'h0000_5001, 2'b11, 1'b0, 32'h0, 32'h0, 2'b00, 1'b1, 32'h77A1_B2C3);
        wait_done("t7", 1'b0, 32'h00A1_B2C3, 0);

        // byte write at offset 3: every lane carries the byte
        start_op(1'b0, 32'h0000_6003, 2'b01, 32'h0000_005A);
        bus_cycle("t8", 32'h0000_6003, 2'b01, 1'b1, 32'hFFFF_FFFF, 32'h5A5A_5A5A, 2'b00, 1'b1, 32'h0);
        wait_done("t8", 1'b0, 32'h0, 0);

        // asynchronous reset in the middle of a strobe
        start_op(1'b1, 32'h0000_7000, 2'b00, 32'h0);
        for (int n = 0; n < 40 && u_bus.as_n !== 1'b0; n++) @(negedge clock);
        chk("rstmid.strobe", 32'(u_bus.as_n), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("rstmid.as_n", 32'(u_bus.as_n), 32'd1);
        chk("rstmid.ds_n", 32'(u_bus.ds_n), 32'd1);
        chk("rstmid.busy", 32'(u_bus.busy), 32'd0);
        chk("rstmid.addr", u_bus.addr, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        activity = 0;
        repeat (5) begin
            @(negedge clock);
            if (u_bus.as_n === 1'b0 || u_bus.done === 1'b1) activity++;
        end
        chk("rstmid.quiet", 32'(activity), 32'd0);

`ifdef BUS_SEQ_TIMEOUT_EN
        // no DSACK at all: forced error after 16 strobe clocks
        start_op(1'b1, 32'h0000_8000, 2'b00, 32'h0);
        wait_done("t6", 1'b1, 32'h0, 16);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
